// File: rtl/mem_sram_pkg.sv
// Shared types and defaults for the 32-bit to 16-bit asynchronous SRAM memory-stage sequencer.
package mem_sram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } sram_state_e;

  localparam int unsigned SramDw      = 16;
  localparam logic [31:0] DefBaseAddr = 32'd1024;
  localparam int unsigned DefSramAw   = 18;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half-word wait counter: load clears it, enable advances it, and it saturates at the terminal count.
module sram_wait_counter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CntW'(ACCESS_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory-stage sequencer: splits each 32-bit load/store into two 16-bit SRAM accesses
// (low half first) and freezes the pipeline until the access completes.
module mem_sram_ctrl
  import mem_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DefBaseAddr,
  parameter int unsigned SRAM_AW       = DefSramAw,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               mem_r_en_i,
  input  logic               mem_w_en_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               ready_o,
  output logic               freeze_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [SramDw-1:0]  sram_dq_out_o,
  input  logic [SramDw-1:0]  sram_dq_in_i,
  output logic               sram_dq_oe_o,
  output logic               sram_we_n_o
);

  localparam int unsigned WidxW = SRAM_AW - 1;

  sram_state_e        state_q, state_d;
  logic [WidxW-1:0]   widx_q, widx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               rd_q, rd_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic               cnt_load, cnt_en, cnt_tc;
  logic               access, wr_access;

  sram_wait_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_wait_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load_i(cnt_load),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_r_en_i || mem_w_en_i) begin
          // Read wins when both are requested; the store is dropped.
          widx_d      = WidxW'((addr_i - BASE_ADDR) >> 2);
          wdata_d     = wdata_i;
          rd_d        = mem_r_en_i;
          sram_addr_d = {widx_d, 1'b0};
          cnt_load    = 1'b1;
          state_d     = StLo;
        end
      end
      StLo: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          if (rd_q) rdata_d[SramDw-1:0] = sram_dq_in_i;
          sram_addr_d = {widx_q, 1'b1};
          cnt_load    = 1'b1;
          state_d     = StHi;
        end
      end
      StHi: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          if (rd_q) rdata_d[31:SramDw] = sram_dq_in_i;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      widx_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
    end
  end

  assign access    = (state_q == StLo) || (state_q == StHi);
  assign wr_access = access && !rd_q;

  assign rdata_o       = rdata_q;
  assign ready_o       = (state_q == StDone);
  assign freeze_o      = (mem_r_en_i | mem_w_en_i) & ~ready_o;
  assign sram_addr_o   = sram_addr_q;
  assign sram_we_n_o   = ~wr_access;
  assign sram_dq_oe_o  = wr_access;
  assign sram_dq_out_o = !wr_access        ? '0 :
                         (state_q == StHi) ? wdata_q[31:SramDw] : wdata_q[SramDw-1:0];

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench: one controller at two SRAM cycles per half-word and one at a single cycle,
// each attached to a small behavioural SRAM.
module tb_mem_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        r0 = 0, w0 = 0, r1 = 0, w1 = 0;
  logic [31:0] a0 = 0, d0 = 0, a1 = 0, d1 = 0;
  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1, fz0, fz1, oe0, oe1, we0, we1;
  logic [17:0] sa0, sa1;
  logic [15:0] dqo0, dqo1, dqi0, dqi1;

  logic [15:0] mem0 [64] = '{default: 16'h0};
  logic [15:0] mem1 [64] = '{default: 16'h0};

  always @(posedge clk) if (!we0) mem0[sa0[5:0]] <= dqo0;
  always @(posedge clk) if (!we1) mem1[sa1[5:0]] <= dqo1;
  assign dqi0 = mem0[sa0[5:0]];
  assign dqi1 = mem1[sa1[5:0]];

  mem_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .ACCESS_CYCLES(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .mem_r_en_i(r0), .mem_w_en_i(w0), .addr_i(a0),
    .wdata_i(d0), .rdata_o(rd0), .ready_o(rdy0), .freeze_o(fz0), .sram_addr_o(sa0),
    .sram_dq_out_o(dqo0), .sram_dq_in_i(dqi0), .sram_dq_oe_o(oe0), .sram_we_n_o(we0)
  );

  mem_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .ACCESS_CYCLES(1)) u_dut_a1 (
    .clk_i(clk), .rst_ni(rst_n), .mem_r_en_i(r1), .mem_w_en_i(w1), .addr_i(a1),
    .wdata_i(d1), .rdata_o(rd1), .ready_o(rdy1), .freeze_o(fz1), .sram_addr_o(sa1),
    .sram_dq_out_o(dqo1), .sram_dq_in_i(dqi1), .sram_dq_oe_o(oe1), .sram_we_n_o(we1)
  );

  // Selected instance view for the shared access task.
  logic        sel = 1'b0;
  logic [31:0] s_rdata;
  logic        s_ready, s_freeze, s_oe, s_we_n;
  logic [17:0] s_addr;
  logic [15:0] s_dq;
  always_comb begin
    s_rdata  = sel ? rd1  : rd0;
    s_ready  = sel ? rdy1 : rdy0;
    s_freeze = sel ? fz1  : fz0;
    s_oe     = sel ? oe1  : oe0;
    s_we_n   = sel ? we1  : we0;
    s_addr   = sel ? sa1  : sa0;
    s_dq     = sel ? dqo1 : dqo0;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin r1 = r; w1 = w; a1 = a; d1 = d; end
    else     begin r0 = r; w0 = w; a0 = a; d0 = d; end
  endtask

  logic [17:0] tr_addr [16];
  logic [15:0] tr_dq   [16];
  logic        tr_we_n [16];
  logic        tr_oe   [16];
  int          rdy_idx, fz_n, we_low, rdy_cyc;
  logic [31:0] rd_done;

  // Presents a request and samples every cycle until ready (bounded); request stays asserted.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    set_req(r, w, a, d);
    rdy_idx = -1; fz_n = 0; we_low = 0; rd_done = 'x; rdy_cyc = -1;
    for (int i = 0; i < 16; i++) begin
      #1;
      tr_addr[i] = s_addr; tr_dq[i] = s_dq; tr_we_n[i] = s_we_n; tr_oe[i] = s_oe;
      if (s_freeze) fz_n++;
      if (!s_we_n) we_low++;
      if (s_ready) begin
        rdy_idx = i; rd_done = s_rdata; rdy_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int viol;
    int c1;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_rdata", rd0, 32'h0);
    check_eq("rst_ready", {31'h0, rdy0}, 32'h0);
    check_eq("rst_freeze", {31'h0, fz0}, 32'h0);
    check_eq("rst_sram_addr", {14'h0, sa0}, 32'h0);
    check_eq("rst_dq_out", {16'h0, dqo0}, 32'h0);
    check_eq("rst_dq_oe", {31'h0, oe0}, 32'h0);
    check_eq("rst_we_n", {31'h0, we0}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (fz0 || rdy0 || !we0 || oe0) viol++;
    end
    check_eq("idle_bus_quiet", viol, 0);

    // Store 0xDEADBEEF to byte 1032 -> half-words 4 (low) and 5 (high).
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
    idle();
    check_eq("st_ready_idx", rdy_idx, 5);
    check_eq("st_freeze_cycles", fz_n, 5);
    check_eq("st_we_low_cycles", we_low, 4);
    check_eq("st_idle_we_n", {31'h0, tr_we_n[0]}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      check_eq($sformatf("st_addr_%0d", i), {14'h0, tr_addr[i]}, (i < 3) ? 32'd4 : 32'd5);
      check_eq($sformatf("st_dq_%0d", i), {16'h0, tr_dq[i]}, (i < 3) ? 32'hBEEF : 32'hDEAD);
      check_eq($sformatf("st_we_n_%0d", i), {31'h0, tr_we_n[i]}, 32'h0);
      check_eq($sformatf("st_oe_%0d", i), {31'h0, tr_oe[i]}, 32'h1);
    end
    check_eq("st_mem_lo", {16'h0, mem0[4]}, 32'hBEEF);
    check_eq("st_mem_hi", {16'h0, mem0[5]}, 32'hDEAD);

    access(1'b1, 1'b0, 32'd1032, 32'h0);
    idle();
    check_eq("ld_ready_idx", rdy_idx, 5);
    check_eq("ld_rdata", rd_done, 32'hDEADBEEF);
    check_eq("ld_no_we", we_low, 0);

    // Both enables set: the read wins and the SRAM is left untouched.
    access(1'b0, 1'b1, 32'd1024, 32'h22221111);
    idle();
    access(1'b1, 1'b1, 32'd1024, 32'h55555555);
    idle();
    check_eq("rw_rdata", rd_done, 32'h22221111);
    check_eq("rw_no_we", we_low, 0);
    check_eq("rw_mem_lo", {16'h0, mem0[0]}, 32'h1111);
    check_eq("rw_mem_hi", {16'h0, mem0[1]}, 32'h2222);

    // Reset in the first HI cycle of a store to byte 1036 (half-words 6, 7).
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'd1036, 32'hCAFEF00D);
    repeat (3) @(negedge clk);
    #1;
    check_eq("abort_in_hi_addr", {14'h0, sa0}, 32'd7);
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_eq("abort_rdata", rd0, 32'h0);
    check_eq("abort_ready", {31'h0, rdy0}, 32'h0);
    check_eq("abort_freeze", {31'h0, fz0}, 32'h0);
    check_eq("abort_sram_addr", {14'h0, sa0}, 32'h0);
    check_eq("abort_dq_out", {16'h0, dqo0}, 32'h0);
    check_eq("abort_dq_oe", {31'h0, oe0}, 32'h0);
    check_eq("abort_we_n", {31'h0, we0}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_hi_unwritten", {16'h0, mem0[7]}, 32'h0);
    access(1'b0, 1'b1, 32'd1036, 32'h12345678);
    idle();
    check_eq("post_rst_ready_idx", rdy_idx, 5);
    check_eq("post_rst_mem_lo", {16'h0, mem0[6]}, 32'h5678);
    check_eq("post_rst_mem_hi", {16'h0, mem0[7]}, 32'h1234);
    check_eq("rdata_hold_on_write", rd0, 32'h0);

    // Single-cycle SRAM instance: back-to-back loads.
    sel = 1'b1;
    access(1'b0, 1'b1, 32'd1024, 32'hAAAA5555);
    idle();
    access(1'b0, 1'b1, 32'd1028, 32'h0F0FF0F0);
    idle();
    check_eq("a1_mem_w1_lo", {16'h0, mem1[2]}, 32'hF0F0);
    access(1'b1, 1'b0, 32'd1024, 32'h0);
    c1 = rdy_cyc;
    check_eq("b2b0_ready_idx", rdy_idx, 3);
    check_eq("b2b0_freeze", fz_n, 3);
    check_eq("b2b0_rdata", rd_done, 32'hAAAA5555);
    access(1'b1, 1'b0, 32'd1028, 32'h0);
    idle();
    check_eq("b2b1_ready_idx", rdy_idx, 3);
    check_eq("b2b1_freeze", fz_n, 3);
    check_eq("b2b1_rdata", rd_done, 32'h0F0FF0F0);
    check_eq("b2b_done_spacing", rdy_cyc - c1, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
Sequences memory-stage accesses from the EXE/MEM pipeline register onto an external 16-bit asynchronous SRAM. Each 32-bit read or write is split into two 16-bit half-word accesses, low half first. While an access is in progress, the block freezes the pipeline. It sits between the EXE/MEM register outputs and the MEM/WB register inputs, and replaces single-cycle data memory.

Parameters:
BASE_ADDR, 1024, byte address mapped to SRAM word 0
SRAM_AW, 18, SRAM half-word address width
ACCESS_CYCLES, 2, clock cycles held per 16-bit SRAM access (must be at least 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
mem_r_en  in  1  load request from EXE/MEM register
mem_w_en  in  1  store request from EXE/MEM register
addr  in  32  byte address (ALU result)
wdata  in  32  store data (Rm value)
rdata  out  32  load data
ready  out  1  access complete this cycle
freeze  out  1  stall pipeline registers and PC
sram_addr  out  SRAM_AW  half-word address
sram_dq_out  out  16  write data to SRAM
sram_dq_in  in  16  read data from SRAM
sram_dq_oe  out  1  drive dq bus (top level builds the tristate)
sram_we_n  out  1  SRAM write strobe, active low

Behaviour:
- Reset (rst low, asynchronous):
  - state goes to IDLE.
  - rdata=0, ready=0, freeze=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - Reset arriving mid-access aborts the access immediately. No partial-completion signalling.
- Word index: widx = (addr - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits. Subtraction wraps modulo 2^32; addr[1:0] is ignored.
- Half-word addresses: low half = {widx,0}, high half = {widx,1}.
- States: IDLE, LO, HI, DONE. A counter cnt runs from 0 to ACCESS_CYCLES-1 within LO and HI.
- IDLE:
  - If mem_r_en or mem_w_en is set, latch addr, wdata and op, then go to LO with cnt=0.
  - If both are set, the access is a read; the write is dropped.
- LO:
  - sram_addr = {widx,0}.
  - Write: sram_dq_out=wdata[15:0], sram_dq_oe=1, sram_we_n=0 for every LO cycle.
  - Read: sram_we_n=1, sram_dq_oe=0; rdata[15:0] is captured from sram_dq_in at the edge ending the last LO cycle.
  - Go to HI when cnt==ACCESS_CYCLES-1.
- HI: same as LO using {widx,1} and bits [31:16]. Go to DONE when cnt==ACCESS_CYCLES-1.
- DONE: ready=1 for exactly one cycle, then go to IDLE.
- Outputs: ready is decoded combinationally from state==DONE. freeze = (mem_r_en | mem_w_en) & ~ready, combinational.
- Latency:
  - A request seen in IDLE at cycle T produces LO on T+1..T+A, HI on T+A+1..T+2A, and DONE at T+2A+1, with A=ACCESS_CYCLES.
  - freeze is high from T through T+2A, i.e. 2A+1 cycles (5 at the default).
- Back-to-back: the pipeline advances on the DONE edge, so a new request is sampled in the following IDLE cycle. One idle cycle always separates accesses, and there is no double-issue of the same request.
- rdata holds its last value until the next read completes. It is valid during DONE of a read and is unchanged by writes.
- Request inputs are ignored outside IDLE; the latched copies are used.
- Outside LO and HI: sram_we_n=1, sram_dq_oe=0, and sram_addr holds its last value.

Decomposition:
- Package mem_sram_pkg: state enum (IDLE, LO, HI, DONE), SRAM data width constant 16, default BASE_ADDR and SRAM_AW.
- One natural sub-module: sram_wait_counter. It takes a load/enable input, provides a terminal-count output, and is parameterised by ACCESS_CYCLES.

Test Plan:
- Idle bus: mem_r_en=mem_w_en=0 for 10 cycles -> freeze=0, ready=0, sram_we_n=1, sram_dq_oe=0 throughout.
- Store: mem_w_en=1, addr=1032, wdata=0xDEADBEEF ->
  - sram_addr=4 with dq=0xBEEF and we_n=0 for 2 cycles, then sram_addr=5 with dq=0xDEAD and we_n=0 for 2 cycles.
  - ready pulses at cycle 6; freeze is high for exactly 5 cycles.
- Load after store: mem_r_en=1, addr=1032, SRAM model preloaded -> rdata=0xDEADBEEF in the DONE cycle; no we_n activity.
- Simultaneous mem_r_en=mem_w_en=1 at addr=1024 -> read sequence only; SRAM contents unchanged; rdata = stored word 0.
- Reset pulled low during HI of a store -> all outputs return to reset values asynchronously. After release, a fresh store completes normally, and the aborted high half is never written.
- Back-to-back loads with ACCESS_CYCLES=1: addresses 1024 then 1028 -> each load has freeze high for 3 cycles, with one IDLE cycle between the two DONE pulses.
